pc_unit: RTL and testbench

Parametrised program-counter unit for the WISC pipeline fetch stage. It owns the PC register, evaluates the 3-bit branch condition against the {Z,V,N} flags, and selects between sequential, PC-relative and register-indirect next addresses. It also supports stall, a flag-readiness interlock, a sticky halt state, a one-cycle flush pulse, and a retired-fetch counter. It replaces the purely combinational next-PC logic and feeds the instruction-memory address port and the IF/ID register.

---
 rtl/pc_unit.sv | 103 ++++++++++
 tb/tb_pc_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter. Owns the PC register, resolves the
// 3-bit branch condition against {Z,V,N}, chooses sequential / PC-relative /
// register-indirect next address, and provides stall, flag interlock, sticky
// halt, a one-cycle flush pulse and a retired-fetch (advance) counter.
module pc_unit #(
  parameter int               WIDTH    = 16,
  parameter int               IMM_W    = 9,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch,
  input  logic             branch_reg,
  input  logic [2:0]       cond,
  input  logic [2:0]       flags,
  input  logic             flags_valid,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] reg_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus2,
  output logic             taken,
  output logic             branch_wait,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] adv_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state;
  logic             run;
  logic             is_br;
  logic             cond_true;
  logic             advance;
  logic             enter_halt;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] b_target;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] target;

  wire flag_z = flags[2];
  wire flag_v = flags[1];
  wire flag_n = flags[0];

  // Branch condition truth table over {Z,V,N}
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000: cond_true = !flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = !flag_z && !flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z || !flag_n;
      3'b101: cond_true = flag_n || flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign run      = (state == RUN);
  assign is_br    = branch | branch_reg;
  assign pc_plus2 = pc + WIDTH'(2);

  // Unconditional branches never wait; only flag-dependent ones interlock.
  assign branch_wait = is_br & (cond != 3'b111) & !flags_valid & run & !stall;
  assign taken       = is_br & cond_true & run & !stall & !branch_wait;

  // Targets wrap modulo 2^WIDTH; BR forces halfword alignment, BR beats B.
  assign imm_ext   = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign b_target  = pc_plus2 + (imm_ext << 1);
  assign br_target = {reg_target[WIDTH-1:1], 1'b0};
  assign target    = branch_reg ? br_target : b_target;

  // halt sits below stall/wait in priority but above a taken branch.
  assign advance    = run & !stall & !branch_wait & !halt;
  assign enter_halt = run & !stall & !branch_wait & halt;

  // PC, run/halt FSM, flush pulse and advance counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      halted    <= 1'b0;
      flush     <= 1'b0;
      adv_count <= '0;
    end else begin
      flush <= advance & taken;
      if (advance) begin
        pc        <= taken ? target : pc_plus2;
        adv_count <= adv_count + CNT_W'(1);
      end
      if (enter_halt) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven condition sweep plus hand-written sequences for
// wrap, interlock, stall, priority and halt; per-cycle expectations flow
// through a scoreboard queue and are compared after each rising edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, halt, branch, branch_reg, flags_valid;
  logic [2:0]  cond, flags;
  logic [8:0]  imm;
  logic [15:0] reg_target;
  logic [15:0] pc, pc_plus2, adv_count;
  logic        taken, branch_wait, flush, halted;

  pc_unit #(.WIDTH(16), .IMM_W(9), .RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .branch(branch),
    .branch_reg(branch_reg), .cond(cond), .flags(flags),
    .flags_valid(flags_valid), .imm(imm), .reg_target(reg_target),
    .pc(pc), .pc_plus2(pc_plus2), .taken(taken), .branch_wait(branch_wait),
    .flush(flush), .halted(halted), .adv_count(adv_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        flush;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [2:0] cond;
    logic [2:0] flags;
    logic       exp_taken;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[64];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_halted = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic br, input logic brr, input logic [2:0] c,
                       input logic [2:0] f, input logic fv, input logic [8:0] im,
                       input logic [15:0] tgt, input logic st, input logic hl);
    branch = br; branch_reg = brr; cond = c; flags = f; flags_valid = fv;
    imm = im; reg_target = tgt; stall = st; halt = hl;
  endtask

  // Push the expected post-edge state, clock once, pop and compare.
  task automatic step(input string nm, input logic [15:0] epc, input logic efl,
                      input logic adv);
    exp_t e, g;
    if (adv) exp_cnt = exp_cnt + 16'd1;
    e.pc = epc; e.flush = efl; e.halted = exp_halted; e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({nm, ".pc"}, 32'(pc), 32'(g.pc));
    chk({nm, ".flush"}, 32'(flush), 32'(g.flush));
    chk({nm, ".halted"}, 32'(halted), 32'(g.halted));
    chk({nm, ".adv_count"}, 32'(adv_count), 32'(g.cnt));
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 9'd0, 16'h0000, 1'b0, 1'b0);
  endtask

  // Unconditional BR used to position the PC; it flushes like any taken branch.
  task automatic jump_to(input logic [15:0] a);
    drive(1'b0, 1'b1, 3'b111, 3'b000, 1'b1, 9'd0, a, 1'b0, 1'b0);
    step("jump", a, 1'b1, 1'b1);
  endtask

  initial begin
    logic [7:0] masks[8];
    logic [7:0] m;
    // bit f of masks[c] = expected truth of cond c with flags f ({Z,V,N})
    masks[0] = 8'h0F; masks[1] = 8'hF0; masks[2] = 8'h05; masks[3] = 8'hAA;
    masks[4] = 8'hF5; masks[5] = 8'hFA; masks[6] = 8'hCC; masks[7] = 8'hFF;
    for (int i = 0; i < 64; i++) begin
      m = masks[i / 8];
      vt[i].cond      = 3'(i / 8);
      vt[i].flags     = 3'(i % 8);
      vt[i].exp_taken = m[i % 8];
    end

    // Reset state
    rst = 1'b1;
    idle();
    #1;
    chk("rst.pc", 32'(pc), 32'h0);
    chk("rst.pc_plus2", 32'(pc_plus2), 32'h2);
    chk("rst.halted", 32'(halted), 32'h0);
    chk("rst.flush", 32'(flush), 32'h0);
    chk("rst.adv_count", 32'(adv_count), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sequential fetch: 0,2,4,6,8 then on to 0x10
    for (int k = 1; k <= 8; k++) step("seq", 16'(2 * k), 1'b0, 1'b1);
    chk("seq.count8", 32'(adv_count), 32'd8);

    // Condition sweep: B imm=+3 at pc=0x10
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, vt[i].cond, vt[i].flags, 1'b1, 9'd3, 16'h0000, 1'b0, 1'b0);
      #1;
      chk($sformatf("sweep.taken c%0d f%0d", vt[i].cond, vt[i].flags),
          32'(taken), 32'(vt[i].exp_taken));
      chk("sweep.wait", 32'(branch_wait), 32'h0);
      step("sweep", vt[i].exp_taken ? 16'h0018 : 16'h0012, vt[i].exp_taken, 1'b1);
      jump_to(16'h0010);
    end

    // Negative offset landing on itself: 0 + 2 - 2 = 0, still counts
    jump_to(16'h0000);
    drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 9'h1FF, 16'h0, 1'b0, 1'b0);
    step("self_b", 16'h0000, 1'b1, 1'b1);
    idle();
    step("after_self", 16'h0002, 1'b0, 1'b1);
    // Downward wrap: 0x0002 + 2 - 8 = 0xFFFC
    drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b1, 9'h1FC, 16'h0, 1'b0, 1'b0);
    step("wrap_down", 16'hFFFC, 1'b1, 1'b1);
    // Upward wrap: 0xFFFC + 2 + 6 = 0x0004
    drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b1, 9'd3, 16'h0, 1'b0, 1'b0);
    step("wrap_up", 16'h0004, 1'b1, 1'b1);
    // Sequential wrap from 0xFFFE
    jump_to(16'hFFFE);
    idle();
    #1;
    chk("wrap.pc_plus2", 32'(pc_plus2), 32'h0);
    step("wrap_seq", 16'h0000, 1'b0, 1'b1);

    // BR interlock, Z=1 -> taken to aligned 0x1234
    jump_to(16'h0100);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 3'b001, 3'b100, 1'b0, 9'd0, 16'h1235, 1'b0, 1'b0);
      #1;
      chk("ilk.wait", 32'(branch_wait), 32'h1);
      chk("ilk.taken", 32'(taken), 32'h0);
      step("ilk_hold", 16'h0100, 1'b0, 1'b0);
    end
    flags_valid = 1'b1;
    #1;
    chk("ilk.release_taken", 32'(taken), 32'h1);
    step("ilk_go", 16'h1234, 1'b1, 1'b1);
    idle();
    step("ilk_flush_clr", 16'h1236, 1'b0, 1'b1);
    // Same interlock with Z=0 -> falls through
    jump_to(16'h0100);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 9'd0, 16'h1235, 1'b0, 1'b0);
      step("ilk2_hold", 16'h0100, 1'b0, 1'b0);
    end
    flags_valid = 1'b1;
    #1;
    chk("ilk2.taken", 32'(taken), 32'h0);
    step("ilk2_go", 16'h0102, 1'b0, 1'b1);

    // Stall beats a taken branch
    drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b1, 9'd3, 16'h0, 1'b1, 1'b0);
    #1;
    chk("stall.taken", 32'(taken), 32'h0);
    chk("stall.wait", 32'(branch_wait), 32'h0);
    step("stall", 16'h0102, 1'b0, 1'b0);
    // branch and branch_reg together: BR target wins
    drive(1'b1, 1'b1, 3'b111, 3'b000, 1'b1, 9'd3, 16'h0201, 1'b0, 1'b0);
    step("both", 16'h0200, 1'b1, 1'b1);
    // BR to itself still counts, back-to-back flush
    drive(1'b0, 1'b1, 3'b111, 3'b000, 1'b1, 9'd0, 16'h0200, 1'b0, 1'b0);
    step("br_self", 16'h0200, 1'b1, 1'b1);

    // Halt beats a simultaneous taken branch
    jump_to(16'h0040);
    drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b1, 9'd3, 16'h0, 1'b0, 1'b1);
    exp_halted = 1'b1;
    step("halt", 16'h0040, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(k[0], k[1], 3'(k), 3'(7 - k), k < 5, 9'd3, 16'h0300, 1'b0, k[2]);
      #1;
      chk("halted.taken", 32'(taken), 32'h0);
      chk("halted.wait", 32'(branch_wait), 32'h0);
      step("halted", 16'h0040, 1'b0, 1'b0);
    end

    // Async reset mid-HALTED, with a branch pending across release
    drive(1'b1, 1'b0, 3'b111, 3'b000, 1'b1, 9'd3, 16'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.pc", 32'(pc), 32'h0);
    chk("arst.halted", 32'(halted), 32'h0);
    chk("arst.adv_count", 32'(adv_count), 32'h0);
    exp_halted = 1'b0;
    exp_cnt = 16'd0;
    @(posedge clk);
    #1;
    chk("arst.hold_pc", 32'(pc), 32'h0);
    rst = 1'b0;
    step("post_rst_b", 16'h0008, 1'b1, 1'b1);
    idle();
    step("post_rst_seq", 16'h000A, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end (t=%0t)", $time);
    $fatal(1);
  end

endmodule
